// File: rtl/loop_gear_controller.sv
// Loop-filter bandwidth scheduler for the digital PLL.
// The controller counts loop-filter shift pulses over fixed measurement
// windows. As the loop settles it steps the K-counter modulus gear from
// widest to narrowest, and it declares lock at the last gear. A noisy window
// while tracking clears the filter and restarts acquisition.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | disabled; gear 0, unlocked, counters held at zero
//   ACQUIRE | measuring windows; quiet runs step the gear toward narrow
//   TRACK   | locked at narrowest gear; a noisy window means loss of lock
//   LOST    | single cycle; clears the loop filter, then re-acquires
module loop_gear_controller #(
   parameter int WINDOW_W      = 8,
   parameter int CNT_W         = 8,
   parameter int MAX_GEAR      = 3,
   parameter int LOCK_THRESH   = 2,
   parameter int UNLOCK_THRESH = 8,
   parameter int LOCK_WINDOWS  = 4,
   localparam int GW = (MAX_GEAR > 0) ? $clog2(MAX_GEAR + 1) : 1
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          enable_i,
   input  logic          positiveShift_i,
   input  logic          negativeShift_i,
   output logic [GW-1:0] gear_o,
   output logic          filterClear_o,
   output logic          locked_o,
   output logic [1:0]    state_o
);

   localparam int QW = (LOCK_WINDOWS > 0) ? $clog2(LOCK_WINDOWS + 1) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2,
      LOST    = 2'd3
   } gearState_e;

   gearState_e          state;
   gearState_e          stateNext;
   logic [WINDOW_W-1:0] windowCnt;
   logic [WINDOW_W-1:0] windowCntNext;
   logic [CNT_W-1:0]    shiftTotal;
   logic [CNT_W-1:0]    shiftTotalNext;
   logic [QW-1:0]       quietRun;
   logic [QW-1:0]       quietRunNext;
   logic [GW-1:0]       gearNext;
   logic                filterClearNext;
   logic                lockedNext;

   logic [CNT_W:0]      shiftSum;
   logic [CNT_W-1:0]    totalNow;
   logic                running;
   logic                windowEnd;
   logic                windowQuiet;
   logic                windowNoisy;
   logic                quietRunDone;
   logic                stepGear;

   // Window measurement: this cycle's pulses are folded into the judged total
   // so a pulse landing exactly on the window end still counts.
   always_comb begin
      running      = (state == ACQUIRE) || (state == TRACK);
      windowEnd    = running && (windowCnt == '1);
      shiftSum     = {1'b0, shiftTotal}
                   + (CNT_W + 1)'(positiveShift_i)
                   + (CNT_W + 1)'(negativeShift_i);
      totalNow     = shiftSum[CNT_W] ? '1 : shiftSum[CNT_W-1:0];
      windowQuiet  = int'(totalNow) <= LOCK_THRESH;
      windowNoisy  = int'(totalNow) > UNLOCK_THRESH;
      quietRunDone = (int'(quietRun) + 1) == LOCK_WINDOWS;
   end

   // Next-state decision and registered output values; enable low overrides
   // every transition except staying in IDLE.
   always_comb begin
      stateNext = state;
      stepGear  = 1'b0;
      case (state)
         IDLE: begin
            if (enable_i) stateNext = ACQUIRE;
         end
         ACQUIRE: begin
            if (windowEnd && windowQuiet && quietRunDone) begin
               if (int'(gear_o) < MAX_GEAR) stepGear  = 1'b1;
               else                         stateNext = TRACK;
            end
         end
         TRACK: begin
            if (windowEnd && windowNoisy) stateNext = LOST;
         end
         LOST: begin
            stateNext = ACQUIRE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      if (!enable_i && (state != IDLE)) begin
         stateNext = IDLE;
         stepGear  = 1'b0;
      end

      gearNext = '0;
      if ((stateNext == ACQUIRE) || (stateNext == TRACK))
         gearNext = stepGear ? gear_o + 1'b1 : gear_o;
      filterClearNext = ((state == IDLE) && (stateNext == ACQUIRE))
                      || (stateNext == LOST);
      lockedNext      = (stateNext == TRACK);
   end

   // Window, shift and quiet-run counters; every state change restarts them.
   always_comb begin
      windowCntNext  = '0;
      shiftTotalNext = '0;
      quietRunNext   = '0;
      if (running && (stateNext == state)) begin
         windowCntNext  = windowCnt + 1'b1;
         shiftTotalNext = windowEnd ? '0 : totalNow;
         quietRunNext   = quietRun;
         if (windowEnd) begin
            if (!windowQuiet || stepGear) quietRunNext = '0;
            else if (quietRun != '1)      quietRunNext = quietRun + 1'b1;
         end
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state         <= IDLE;
         windowCnt     <= '0;
         shiftTotal    <= '0;
         quietRun      <= '0;
         gear_o        <= '0;
         filterClear_o <= 1'b0;
         locked_o      <= 1'b0;
      end else begin
         state         <= stateNext;
         windowCnt     <= windowCntNext;
         shiftTotal    <= shiftTotalNext;
         quietRun      <= quietRunNext;
         gear_o        <= gearNext;
         filterClear_o <= filterClearNext;
         locked_o      <= lockedNext;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_loop_gear_controller.sv
// Directed bench for loop_gear_controller with default parameters
// (256-cycle windows, gears 0..3, 4 quiet windows per step).
module tb_loop_gear_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       pos;
   logic       neg;
   logic [1:0] gear;
   logic       clr;
   logic       lk;
   logic [1:0] st;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int s;
   int s2;
   int s3;

   always #5 clk = ~clk;

   loop_gear_controller dut (
      .clk_i           (clk),
      .reset_i         (rst),
      .enable_i        (en),
      .positiveShift_i (pos),
      .negativeShift_i (neg),
      .gear_o          (gear),
      .filterClear_o   (clr),
      .locked_o        (lk),
      .state_o         (st)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic runTo(input int n);
      while (cyc < n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chkAll(input string tag, input int eSt, input int eGear,
                         input int eClr, input int eLk);
      chk({tag, ".state"},       32'(st),   eSt);
      chk({tag, ".gear"},        32'(gear), eGear);
      chk({tag, ".filterClear"}, 32'(clr),  eClr);
      chk({tag, ".locked"},      32'(lk),   eLk);
   endtask

   task automatic pulses(input int n, input logic p, input logic q);
      for (int i = 0; i < n; i++) begin
         pos = p;
         neg = q;
         tick();
      end
      pos = 1'b0;
      neg = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      pos = 1'b0;
      neg = 1'b0;
      tick();
      tick();
      chkAll("reset", 0, 0, 0, 0);

      rst = 1'b0;
      tick();
      chkAll("idleDisabled", 0, 0, 0, 0);

      // cycle 0 = first ACQUIRE cycle
      en = 1'b1;
      tick();
      cyc = 0;
      chkAll("startAcq", 1, 0, 1, 0);
      tick();
      chkAll("clearOneCycle", 1, 0, 0, 0);

      // clean acquisition: gear every 4 windows, lock after 16
      runTo(1023); chk("gear0Hold",  32'(gear), 0);
      runTo(1024); chk("gear1Step",  32'(gear), 1);
      runTo(2047); chk("gear1Hold",  32'(gear), 1);
      runTo(2048); chk("gear2Step",  32'(gear), 2);
      runTo(3072); chk("gear3Step",  32'(gear), 3);
      runTo(4095); chkAll("preLock", 1, 3, 0, 0);
      runTo(4096); chkAll("locked", 2, 3, 0, 1);

      // TRACK: 8 pulses in a window is tolerated, 9 loses lock
      runTo(4100); pulses(8, 1'b1, 1'b0);
      runTo(4352); chkAll("track8Stay", 2, 3, 0, 1);
      runTo(4400); pulses(9, 1'b0, 1'b1);
      runTo(4607); chk("track9Pre", 32'(st), 2);
      runTo(4608); chkAll("lost", 3, 0, 1, 0);
      runTo(4609); chkAll("reacquire", 1, 0, 0, 0);
      s = 4609;

      // noisy window at gear 1 (window 5) restarts the quiet run
      runTo(s + 1024); chk("reGear1", 32'(gear), 1);
      runTo(s + 1300); pulses(3, 1'b1, 1'b0);
      runTo(s + 2048); chk("noisyNoStep", 32'(gear), 1);
      runTo(s + 2559); chk("noisyHold", 32'(gear), 1);
      runTo(s + 2560); chk("noisyLateStep", 32'(gear), 2);

      // window 10: one pulse, then both inputs on the window-end cycle -> 3
      runTo(s + 2600); pulses(1, 1'b1, 1'b0);
      runTo(s + 2815); pulses(1, 1'b1, 1'b1);
      runTo(s + 3584); chk("dualEdgeNoStep", 32'(gear), 2);
      runTo(s + 3839); chk("dualEdgeHold", 32'(gear), 2);
      runTo(s + 3840); chk("dualEdgeStep", 32'(gear), 3);
      runTo(s + 4863); chk("reLockPre", 32'(lk), 0);
      runTo(s + 4864); chkAll("reLock", 2, 3, 0, 1);

      // 256 pulses in one TRACK window: saturates at 255 (a wrap would read 0)
      runTo(s + 4870); pulses(128, 1'b1, 1'b1);
      runTo(s + 5119); chk("satPre", 32'(st), 2);
      runTo(s + 5120); chkAll("satLost", 3, 0, 1, 0);
      runTo(s + 5121); chkAll("satReacq", 1, 0, 0, 0);
      s2 = s + 5121;

      // enable dropped while tracking
      runTo(s2 + 4096); chkAll("lock3", 2, 3, 0, 1);
      runTo(s2 + 4200);
      en = 1'b0;
      tick();
      chkAll("disableTrack", 0, 0, 0, 0);
      tick();
      chkAll("disableStay", 0, 0, 0, 0);

      // re-enable, reach gear 1, then asynchronous reset mid-window
      en = 1'b1;
      tick();
      s3 = cyc;
      chkAll("reEnable", 1, 0, 1, 0);
      runTo(s3 + 1023); chk("rGear0", 32'(gear), 0);
      runTo(s3 + 1024); chk("rGear1", 32'(gear), 1);
      runTo(s3 + 1100);
      #2;
      rst = 1'b1;
      #1;
      chkAll("asyncReset", 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      en  = 1'b0;
      tick();
      chkAll("postReset", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
